imem_loader: RTL and testbench

- Write-side counterpart of the instruction memory: fills the word-addressed instruction store at run time from a byte stream, replacing the simulation-only hex preload for hardware bring-up.
- Accepts a valid/ready byte stream: 16-bit word-count header, then big-endian 32-bit instructions.
- Drives a one-word-per-cycle write port addressed with PC-style byte addresses.
- Holds the processor in reset until loading completes.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_byte_packer.sv | 83 ++++++++
 rtl/imem_loader.sv | 194 +++++++++++++++++++
 tb/tb_imem_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory loader and the instruction
// memory itself.
//   state_e     : loader FSM state encoding
//   HDR_BYTES   : bytes in the word-count header
//   WORD_BYTES  : bytes per instruction word
//   IMEM_DEPTH  : default instruction memory depth in words
// Optional build macro used by the loader: IMEM_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int IMEM_DEPTH = 100;

endpackage

// File: rtl/imem_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_byte_packer
// Collects payload bytes MSB-first into 32-bit instruction words.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear_i        : restart packing at byte position 0 (new session)
//   accept_i       : a payload byte is consumed this cycle
//   byte_i         : the payload byte
//   word_ready_o   : high in the cycle the 4th byte of a word is consumed
//   word_o         : assembled word; valid while word_ready_o is high
//   xor_o          : running XOR of all payload bytes
//                    (only when IMEM_LOADER_CHECKSUM_EN is defined)
// -----------------------------------------------------------------------------
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic        word_ready_o,
  output logic [31:0] word_o
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  xor_o
`endif
);

  logic [1:0]  pos_q, pos_d;
  logic [23:0] shift_q, shift_d;

  // The three earlier bytes plus the byte on the bus form the word, so the
  // top can register it in the same cycle the last byte is consumed.
  assign word_o       = {shift_q, byte_i};
  assign word_ready_o = accept_i && (pos_q == 2'(WORD_BYTES - 1));

  always_comb begin
    pos_d   = pos_q;
    shift_d = shift_q;
    if (clear_i) begin
      pos_d   = '0;
      shift_d = '0;
    end else if (accept_i) begin
      pos_d   = pos_q + 2'd1;
      shift_d = {shift_q[15:0], byte_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      shift_q <= '0;
    end else begin
      pos_q   <= pos_d;
      shift_q <= shift_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;

  always_comb begin
    xor_d = xor_q;
    if (clear_i) begin
      xor_d = '0;
    end else if (accept_i) begin
      xor_d = xor_q ^ byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= '0;
    end else begin
      xor_q <= xor_d;
    end
  end

  assign xor_o = xor_q;
`endif

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Fills the instruction memory at run time from a valid/ready byte stream:
// a 16-bit big-endian word count, then big-endian 32-bit instructions. Holds
// the CPU in reset until the load completes.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : pulse; begins a session from IDLE, DONE or ERR
//   in_valid, in_data  : byte stream from the source
//   in_ready           : loader consumes a byte when in_valid && in_ready
//   mem_we             : one-cycle write strobe per word
//   mem_addr           : byte address of the write (word index << 2)
//   mem_wdata          : instruction word being written
//   cpu_hold           : keeps the CPU/PC in reset
//   done / error       : session outcome levels
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that is verified after the last word (CHK state).
// -----------------------------------------------------------------------------
module imem_loader
  import imem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  localparam int IDX_W = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic             hdr_pos_q, hdr_pos_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic             session_start;
  logic             pack_accept;
  logic             word_ready;
  logic [31:0]      pack_word;
  logic [15:0]      hdr_count;
  logic [15:0]      idx_next16;

  // Kept outside the FSM process so the packer's word_ready (which depends
  // on pack_accept) does not loop back into the same combinational block.
  assign session_start = start &&
                         ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign pack_accept   = in_valid && (state_q == LOAD);

  assign hdr_count  = {count_q[15:8], in_data};
  assign idx_next16 = 16'(idx_q) + 16'd1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] pack_xor;
`endif

  imem_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (session_start),
    .accept_i     (pack_accept),
    .byte_i       (in_data),
    .word_ready_o (word_ready),
    .word_o       (pack_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .xor_o        (pack_xor)
`endif
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hdr_pos_d   = hdr_pos_q;
    idx_d       = idx_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    in_ready    = 1'b0;
    mem_we      = 1'b0;
    cpu_hold    = 1'b1;
    done        = 1'b0;
    error       = 1'b0;

    case (state_q)
      IDLE: begin
      end

      HDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!hdr_pos_q) begin
            count_d[15:8] = in_data;
            hdr_pos_d     = 1'b1;
          end else begin
            count_d   = hdr_count;
            hdr_pos_d = 1'b0;
            if ((hdr_count == 16'd0) || (hdr_count > 16'(DEPTH))) begin
              state_d = ERR;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        // Capture address and data now so they are stable registers during
        // the WRITE cycle and hold afterwards.
        if (word_ready) begin
          mem_addr_d  = WIDTH'(idx_q) << 2;
          mem_wdata_d = WIDTH'(pack_word);
          state_d     = WRITE;
        end
      end

      WRITE: begin
        mem_we = 1'b1;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_next16 == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = LOAD;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (in_data == pack_xor) ? DONE : ERR;
        end
      end
`endif

      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end

      ERR: begin
        error = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (session_start) begin
      state_d   = HDR;
      count_d   = '0;
      hdr_pos_d = 1'b0;
      idx_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      hdr_pos_q   <= 1'b0;
      idx_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hdr_pos_q   <= hdr_pos_d;
      idx_q       <= idx_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(.WIDTH(32), .DEPTH(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim_q[$];
  logic [7:0] run_xor;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe is matched against the next
  // expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr=0x%08h data=0x%08h, required no write",
                   mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
          check("wr_in_ready_low", 32'(in_ready), 32'd0);
          $display("[TB] write addr=0x%08h data=0x%08h", mem_addr, mem_wdata);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic new_stream(input logic [15:0] count);
    stim_q.delete();
    stim_q.push_back(count[15:8]);
    stim_q.push_back(count[7:0]);
    run_xor = 8'h00;
  endtask

  task automatic add_word(input logic [31:0] w, input int idx);
    wr_t e;
    for (int k = 3; k >= 0; k--) begin
      stim_q.push_back(w[k*8 +: 8]);
      run_xor = run_xor ^ w[k*8 +: 8];
    end
    e.addr = 32'(idx) << 2;
    e.data = w;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      guard++;
      if (guard > 100) begin
        tests++;
        fails++;
        $display("FAIL in_ready_timeout: byte 0x%02h not accepted within 100 cycles", b);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input bit gaps);
    foreach (stim_q[i]) send_byte(stim_q[i], gaps);
  endtask

  task automatic start_session();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // After the last payload byte: the loader should report success exactly
  // one cycle after the final write (or after the checksum byte).
  task automatic finish_expect_done(input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(run_xor, 1'b0);
`else
    check({tag, "_done_not_early"}, 32'(done), 32'd0);
    @(posedge clk);
    #1;
`endif
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic two_word_stream();
    new_stream(16'd2);
    add_word(32'h2008_0005, 0);
    add_word(32'h8C09_0004, 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of LOAD, after 6 payload bytes.
    $display("[TB] reset mid-load");
    start_session();
    new_stream(16'd2);
    add_word(32'h2008_0005, 0);
    stim_q.push_back(8'h8C);
    stim_q.push_back(8'h09);
    send_stream(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-word load, valid held high.
    $display("[TB] two-word load, continuous");
    start_session();
    two_word_stream();
    send_stream(1'b0);
    finish_expect_done("load2");

    // Same stream with random valid gaps, started from DONE.
    $display("[TB] two-word load, gaps");
    start_session();
    check("restart_done_cleared", 32'(done), 32'd0);
    two_word_stream();
    send_stream(1'b1);
    finish_expect_done("load2_gaps");

    // Header out of range.
    $display("[TB] header 0x0065");
    start_session();
    send_byte(8'h00, 1'b0);
    send_byte(8'h65, 1'b0);
    check("hdr101_error", 32'(error), 32'd1);
    check("hdr101_in_ready", 32'(in_ready), 32'd0);
    check("hdr101_cpu_hold", 32'(cpu_hold), 32'd1);
    check("hdr101_done", 32'(done), 32'd0);

    $display("[TB] header 0x0000");
    start_session();
    check("err_restart_cleared", 32'(error), 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("hdr0_error", 32'(error), 32'd1);
    check("hdr0_in_ready", 32'(in_ready), 32'd0);

    $display("[TB] recovery after error");
    start_session();
    two_word_stream();
    send_stream(1'b0);
    finish_expect_done("recover");

    // Full-depth load with stray start pulses during LOAD.
    $display("[TB] 100-word load");
    start_session();
    new_stream(16'd100);
    for (int i = 0; i < 100; i++) begin
      add_word({8'(i), 8'hA5, ~8'(i), 8'h3C}, i);
    end
    foreach (stim_q[i]) begin
      if (i == 43 || i == 210 || i == 333) begin
        start_session();
      end
      send_byte(stim_q[i], 1'b0);
    end
    finish_expect_done("load100");
    check("load100_addr_hold", mem_addr, 32'h0000_018C);
    check("load100_data_hold", mem_wdata, 32'h63A5_9C3C);

`ifdef IMEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum good");
    start_session();
    new_stream(16'd1);
    add_word(32'h2008_0005, 0);
    send_stream(1'b0);
    send_byte(8'h2D, 1'b0);
    check("chk_good_done", 32'(done), 32'd1);
    check("chk_good_error", 32'(error), 32'd0);

    $display("[TB] checksum bad");
    start_session();
    new_stream(16'd1);
    add_word(32'h2008_0005, 0);
    send_stream(1'b0);
    send_byte(8'h2C, 1'b0);
    check("chk_bad_error", 32'(error), 32'd1);
    check("chk_bad_done", 32'(done), 32'd0);
    check("chk_bad_cpu_hold", 32'(cpu_hold), 32'd1);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
